// File: rtl/divider_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/cla_subtractor.sv
// Combinational carry-look-ahead subtractor: diff = a + ~b + 1.
// borrow is the inverted carry-out, i.e. set when a < b (unsigned).
module cla_subtractor #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);

   logic [N-1:0] p;
   logic [N-1:0] g;
   logic [N:0]   c;
   logic         acc;
   logic         term;

   // Per-bit propagate/generate against the inverted subtrahend.
   for (genvar i = 0; i < N; i++) begin : g_pg
      assign p[i] = a[i] ^ ~b[i];
      assign g[i] = a[i] & ~b[i];
   end

   // Flattened look-ahead: each carry is the OR of every generate term
   // propagated up to it, plus the carry-in of 1 propagated through all bits.
   always_comb begin
      c    = '0;
      acc  = 1'b0;
      term = 1'b0;
      c[0] = 1'b1;
      for (int i = 0; i < N; i++) begin
         acc = 1'b0;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            acc = acc | term;
         end
         term = 1'b1;
         for (int k = 0; k <= i; k++) term = term & p[k];
         c[i+1] = acc | term;
      end
   end

   assign diff   = p ^ c[N-1:0];
   assign borrow = ~c[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle,
// WIDTH cycles per operation, trial subtraction through a CLA subtractor.
module seq_restoring_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   r;     // partial remainder, one guard bit wide
   logic [WIDTH-1:0] q;     // dividend shifts out the top, quotient in the bottom
   logic [WIDTH-1:0] d;

   logic [WIDTH:0]   rs;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH:0]   r_next;
   logic [WIDTH-1:0] q_next;

   assign rs     = {r[WIDTH-1:0], q[WIDTH-1]};
   assign r_next = borrow ? rs : diff;
   assign q_next = {q[WIDTH-2:0], ~borrow};

   cla_subtractor #(.N(WIDTH + 1)) u_sub (
      .a      (rs),
      .b      ({1'b0, d}),
      .diff   (diff),
      .borrow (borrow)
   );

   assign busy = (state == BUSY);
   assign done = (state == DONE);

   // FSM, iteration datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  r           <= '0;
                  q           <= dividend;
                  d           <= divisor;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
                  if (divisor == '0) begin
                     // No iterations: results are fixed and ready next cycle.
                     state       <= DONE;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= BUSY;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               q   <= q_next;
               r   <= r_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  quotient  <= q_next;
                  remainder <= r_next[WIDTH-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed scenarios
// plus a randomized run against plain integer division.
module tb_seq_restoring_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one start pulse and follow the operation until done (bounded).
   // On return the bench sits in the done cycle (or at the bound).
   task automatic do_op(input int n, input int dv, output int lat, output int nbusy,
                        output bit tmo, output int qo, output int ro, output int zo);
      dividend = W'(n);
      divisor  = W'(dv);
      start    = 1'b1;
      step();
      start = 1'b0;
      lat   = 1;
      nbusy = 0;
      while (!done && lat < 40) begin
         if (busy) nbusy++;
         step();
         lat++;
      end
      tmo = !done;
      qo  = int'(quotient);
      ro  = int'(remainder);
      zo  = int'(div_by_zero);
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) step();
      checks++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%0b done=%0b dbz=%0b q=%0d r=%0d, want all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      rst = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%0b done=%0b, want 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      int tn[5] = '{100, 255, 5, 0, 200};
      int td[5] = '{7, 1, 9, 3, 200};
      int lat, nb, q, r, z;
      bit tmo;
      for (int i = 0; i < 5; i++) begin
         do_op(tn[i], td[i], lat, nb, tmo, q, r, z);
         checks++;
         if (tmo || lat != W + 1 || nb != W) begin
            errors++;
            $display("FAIL basic_latency %0d/%0d: done at %0d busy %0d tmo %0b, want %0d and %0d",
                     tn[i], td[i], lat, nb, tmo, W + 1, W);
         end
         checks++;
         if (q != tn[i] / td[i] || r != tn[i] % td[i] || z != 0) begin
            errors++;
            $display("FAIL basic_result %0d/%0d: q=%0d r=%0d z=%0d, want q=%0d r=%0d z=0",
                     tn[i], td[i], q, r, z, tn[i] / td[i], tn[i] % td[i]);
         end
         step();
      end
   endtask

   task automatic test_div_zero();
      int lat, nb, q, r, z;
      bit tmo;
      do_op(77, 0, lat, nb, tmo, q, r, z);
      checks++;
      if (tmo || lat != 1 || nb != 0) begin
         errors++;
         $display("FAIL div_zero_timing: done at %0d busy %0d, want 1 and 0", lat, nb);
      end
      checks++;
      if (q != 255 || r != 77 || z != 1) begin
         errors++;
         $display("FAIL div_zero_result: q=%0d r=%0d z=%0d, want 255 77 1", q, r, z);
      end
      step();
      checks++;
      if (done !== 1'b0 || quotient !== 8'd255 || remainder !== 8'd77) begin
         errors++;
         $display("FAIL div_zero_hold: done=%0b q=%0d r=%0d, want 0 255 77", done, quotient, remainder);
      end
   endtask

   task automatic test_start_while_busy();
      int lat = 1;
      int extra = 0;
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      step();
      start = 1'b0;
      repeat (3) begin step(); lat++; end
      // busy cycle 4: new operands and a stray start
      dividend = 8'd9;
      divisor  = 8'd3;
      start    = 1'b1;
      step();
      lat++;
      start = 1'b0;
      while (!done && lat < 40) begin step(); lat++; end
      checks++;
      if (lat != W + 1 || quotient !== 8'd14 || remainder !== 8'd2) begin
         errors++;
         $display("FAIL busy_start: done at %0d q=%0d r=%0d, want %0d 14 2", lat, quotient, remainder, W + 1);
      end
      repeat (12) begin step(); if (done) extra++; end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL busy_start_extra_done: %0d extra done cycles, want 0", extra);
      end
   endtask

   task automatic test_reset_mid();
      int dn = 0;
      int lat, nb, q, r, z;
      bit tmo;
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();   // busy cycle 5
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
         errors++;
         $display("FAIL reset_mid: busy=%0b done=%0b dbz=%0b q=%0d r=%0d, want all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end
      repeat (10) begin step(); if (done || busy) dn++; end
      checks++;
      if (dn != 0) begin
         errors++;
         $display("FAIL reset_mid_abort: %0d active cycles after reset, want 0", dn);
      end
      do_op(50, 6, lat, nb, tmo, q, r, z);
      checks++;
      if (tmo || q != 8 || r != 2) begin
         errors++;
         $display("FAIL reset_mid_fresh: q=%0d r=%0d tmo=%0b, want 8 2", q, r, tmo);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int lat, nb, q, r, z;
      int held_bad = 0;
      bit tmo;
      do_op(100, 7, lat, nb, tmo, q, r, z);
      dividend = 8'd64;
      divisor  = 8'd8;
      start    = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: busy=%0b done=%0b, want 1 0", busy, done);
      end
      lat = 1;
      while (!done && lat < 40) begin
         if (quotient !== 8'd14 || remainder !== 8'd2) held_bad++;
         step();
         lat++;
      end
      checks++;
      if (held_bad != 0) begin
         errors++;
         $display("FAIL b2b_hold: %0d cycles with first result disturbed, want 0", held_bad);
      end
      checks++;
      if (lat != W + 1 || quotient !== 8'd8 || remainder !== 8'd0) begin
         errors++;
         $display("FAIL b2b_second: done at %0d q=%0d r=%0d, want %0d 8 0", lat, quotient, remainder, W + 1);
      end
      step();
   endtask

   task automatic test_random();
      int lat, nb, q, r, z, n, dv, eq, er, ez, elat, ebusy;
      bit tmo;
      int bad = 0;
      for (int i = 0; i < 3000; i++) begin
         n = int'($urandom_range(0, 255));
         case ($urandom_range(0, 7))
            0:       dv = 0;
            1, 2:    dv = int'($urandom_range(1, 15));
            default: dv = int'($urandom_range(1, 255));
         endcase
         if (dv == 0) begin
            eq = 255; er = n; ez = 1; elat = 1; ebusy = 0;
         end else begin
            eq = n / dv; er = n % dv; ez = 0; elat = W + 1; ebusy = W;
         end
         do_op(n, dv, lat, nb, tmo, q, r, z);
         checks++;
         if (tmo || q != eq || r != er || z != ez || lat != elat || nb != ebusy ||
             (dv != 0 && (q * dv + r != n || r >= dv))) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random %0d/%0d: q=%0d r=%0d z=%0d lat=%0d busy=%0d, want q=%0d r=%0d z=%0d lat=%0d busy=%0d",
                        n, dv, q, r, z, lat, nb, eq, er, ez, elat, ebusy);
         end
         if ($urandom_range(0, 1) == 1) step();
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      test_reset();
      test_basic();
      test_div_zero();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
